// File: rtl/mic_frame_packer.sv
// mic_frame_packer: packs multi-channel microphone sample vectors into
// sign-extended 32-bit words and posts them to a ping-pong RAM through a
// write-only slave port. Each filled half raises a level irq that the host
// acknowledges; vectors that arrive while the packer is busy are counted
// as overruns.
module mic_frame_packer #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 7
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic                         enable,
  input  logic                         sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]   sample_data,
  input  logic                         irq_ack,
  output logic [ADDR_W-1:0]            ram_address,
  output logic                         ram_chipselect,
  output logic                         ram_clken,
  output logic                         ram_write,
  output logic [31:0]                  ram_writedata,
  output logic [3:0]                   ram_byteenable,
  output logic                         irq,
  output logic                         irq_half,
  output logic [7:0]                   overrun_count
);

  localparam int HALF_WORDS = 1 << (ADDR_W - 1);
  localparam int FRAMES     = (HALF_WORDS - 1) / NUM_CH;
  localparam int OFF_W      = ADDR_W - 1;
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);
  localparam logic [OFF_W-1:0] FRAME_LAST = OFF_W'(FRAMES - 1);
  localparam logic [7:0]       NUM_CH_B   = 8'(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WAIT,
    S_WR,
    S_CLOSE,
    S_FULL
  } state_t;

  state_t                       state_reg;
  logic                         cur_reg;
  logic [1:0]                   pending_reg;
  logic [15:0]                  seq_reg;
  logic [7:0]                   overrun_reg;
  logic [NUM_CH*SAMPLE_W-1:0]   sample_reg;
  logic [CH_W-1:0]              ch_reg;
  logic [OFF_W-1:0]             frame_reg;
  logic [OFF_W-1:0]             wptr_reg;
  logic                         stop_reg;
  logic [ADDR_W-1:0]            addr_reg;
  logic [31:0]                  wdata_reg;
  logic                         wr_reg;
  logic                         irq_reg;
  logic                         irq_half_reg;

  logic [1:0]                   ack_mask;
  logic [1:0]                   pending_next;
  logic                         cur_next;
  logic                         irq_half_next;
  logic                         drop;

  // Per-channel view of the latched vector, channel 0 in the LSBs.
  logic [SAMPLE_W-1:0]          ch_samples [NUM_CH];
  logic signed [SAMPLE_W-1:0]   cur_sample;
  logic [31:0]                  ch_word;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_samples[gi] = sample_reg[gi*SAMPLE_W +: SAMPLE_W];
    end
  endgenerate

  assign cur_sample = ch_samples[ch_reg];
  assign ch_word    = 32'(cur_sample);

  // A vector is dropped whenever it arrives outside WAIT (IDLE ignores it).
  assign drop = sample_valid &&
                (state_reg == S_HDR || state_reg == S_WR ||
                 state_reg == S_CLOSE || state_reg == S_FULL);

  // Pending bookkeeping: the ack clears the currently reported oldest half,
  // then CLOSE marks the just-finished half and flips to the other one.
  // With both halves pending the older one is always the half cur points at.
  always_comb begin
    ack_mask = 2'b00;
    if (irq_ack && (pending_reg != 2'b00))
      ack_mask = irq_half_reg ? 2'b10 : 2'b01;
    pending_next = pending_reg & ~ack_mask;
    cur_next     = cur_reg;
    if (state_reg == S_CLOSE) begin
      pending_next[cur_reg] = 1'b1;
      cur_next              = ~cur_reg;
    end
    irq_half_next = (pending_next == 2'b11) ? cur_next : pending_next[1];
  end

  // Packer state machine with registered RAM-port and irq outputs.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_reg    <= S_IDLE;
      cur_reg      <= 1'b0;
      pending_reg  <= 2'b00;
      seq_reg      <= 16'h0000;
      overrun_reg  <= 8'h00;
      sample_reg   <= '0;
      ch_reg       <= '0;
      frame_reg    <= '0;
      wptr_reg     <= '0;
      stop_reg     <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= 32'h0;
      wr_reg       <= 1'b0;
      irq_reg      <= 1'b0;
      irq_half_reg <= 1'b0;
    end else begin
      wr_reg       <= 1'b0;
      pending_reg  <= pending_next;
      cur_reg      <= cur_next;
      irq_reg      <= (pending_next != 2'b00);
      irq_half_reg <= irq_half_next;

      if (drop && (overrun_reg != 8'hFF))
        overrun_reg <= overrun_reg + 8'd1;

      case (state_reg)
        S_IDLE: begin
          if (enable)
            state_reg <= S_HDR;
        end

        S_HDR: begin
          if (!enable) begin
            state_reg <= S_IDLE;
          end else begin
            wr_reg    <= 1'b1;
            addr_reg  <= {cur_reg, {OFF_W{1'b0}}};
            wdata_reg <= {seq_reg, overrun_reg, NUM_CH_B};
            seq_reg   <= seq_reg + 16'd1;
            wptr_reg  <= OFF_W'(1);
            frame_reg <= '0;
            ch_reg    <= '0;
            stop_reg  <= 1'b0;
            state_reg <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (!enable) begin
            state_reg <= S_IDLE;
          end else if (sample_valid) begin
            sample_reg <= sample_data;
            ch_reg     <= '0;
            stop_reg   <= 1'b0;
            state_reg  <= S_WR;
          end
        end

        S_WR: begin
          wr_reg    <= 1'b1;
          addr_reg  <= {cur_reg, wptr_reg};
          wdata_reg <= ch_word;
          wptr_reg  <= wptr_reg + 1'b1;
          ch_reg    <= ch_reg + 1'b1;
          if (!enable)
            stop_reg <= 1'b1;
          if (ch_reg == CH_LAST) begin
            ch_reg    <= '0;
            frame_reg <= frame_reg + 1'b1;
            if (frame_reg == FRAME_LAST)
              state_reg <= S_CLOSE;
            else if (stop_reg || !enable)
              state_reg <= S_IDLE;
            else
              state_reg <= S_WAIT;
          end
        end

        S_CLOSE: begin
          stop_reg <= 1'b0;
          if (stop_reg || !enable)
            state_reg <= S_IDLE;
          else if (pending_next[cur_next])
            state_reg <= S_FULL;
          else
            state_reg <= S_HDR;
        end

        S_FULL: begin
          if (!pending_next[cur_reg])
            state_reg <= enable ? S_HDR : S_IDLE;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign ram_address    = addr_reg;
  assign ram_writedata  = wdata_reg;
  assign ram_write      = wr_reg;
  assign ram_chipselect = wr_reg;
  assign ram_clken      = wr_reg;
  assign ram_byteenable = {4{wr_reg}};
  assign irq            = irq_reg;
  assign irq_half       = irq_half_reg;
  assign overrun_count  = overrun_reg;

endmodule
